// File: rtl/jesd204b_pkg.sv
// Shared JESD204B definitions: SYSREF mode and state encodings plus the
// LMFC-to-dclk derivation used by both SYSREF and LMFC generators.
package jesd204b_pkg;

   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_GAPPED  = 2'b01,
      MODE_CONT    = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_PULSE,
      ST_GAP
   } sysref_state_e;

   function automatic int lmfc_dclk(input int k, input int f, input int div);
      return (k * f) / div;
   endfunction

endpackage

// File: rtl/jesd204b_sysref_phase_cnt.sv
// Free-running modulo-PERIOD phase counter with a launch-phase compare.
// Never gated by generator state, so SYSREF edges stay phase-locked.
module jesd204b_sysref_phase_cnt #(
   parameter int PERIOD = 8,
   parameter int PH_W   = 3
) (
   input  logic            dclk,
   input  logic            rst,
   input  logic [PH_W-1:0] launch,
   output logic [PH_W-1:0] phase,
   output logic            hit
);

   localparam logic [PH_W-1:0] LAST = PH_W'(PERIOD - 1);

   always_ff @(posedge dclk) begin
      if (rst) begin
         phase <= '0;
      end else if (phase == LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + PH_W'(1);
      end
   end

   assign hit = (phase == launch);

endmodule

// File: rtl/jesd204b_sysref_generator.sv
// JESD204B SYSREF generator: one-shot, gapped and continuous bursts.
// Optional launch-phase skew via JESD204B_SYSREF_GEN_SKEW_EN (adds i_skew).
module jesd204b_sysref_generator
   import jesd204b_pkg::*;
#(
   parameter  int JESD_F           = 1,
   parameter  int JESD_K           = 8,
   parameter  int DCLK_DIV         = 4,
   parameter  int LMFC_PERIOD_MULT = 4,
   parameter  int PULSE_WIDTH      = 2,
   localparam int LMFC_DCLK        = lmfc_dclk(JESD_K, JESD_F, DCLK_DIV),
   localparam int PERIOD           = LMFC_DCLK * LMFC_PERIOD_MULT,
   localparam int PH_W             = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic            dclk,
   input  logic            rst,
   input  logic [1:0]      i_mode,
   input  logic [7:0]      i_pulse_count,
   input  logic            i_start,
   input  logic            i_stop,
`ifdef JESD204B_SYSREF_GEN_SKEW_EN
   input  logic [PH_W-1:0] i_skew,
`endif
   output logic            o_sysref,
   output logic            o_busy,
   output logic            o_done,
   output logic [7:0]      o_pulse_cnt,
   output logic [PH_W-1:0] o_phase
);

   if (PERIOD < 2) begin : g_bad_period
      $error("SYSREF PERIOD must be at least 2");
   end
   if (PULSE_WIDTH < 1 || PULSE_WIDTH >= PERIOD) begin : g_bad_width
      $error("PULSE_WIDTH must satisfy 1 <= PULSE_WIDTH < PERIOD");
   end

   localparam logic [PH_W-1:0] W_LAST = PH_W'(PULSE_WIDTH - 1);

   sysref_state_e   state;
   mode_e           mode_q;
   logic [7:0]      target;
   logic [7:0]      pulse_cnt;
   logic [8:0]      cnt_inc;
   logic [PH_W-1:0] wcnt;
   logic [PH_W-1:0] skew_q;
   logic [PH_W-1:0] skew_in;
   logic [PH_W-1:0] launch;
   logic [PH_W-1:0] phase;
   logic            hit;
   logic            stop_pend;
   logic            last_pulse;
   logic            sysref;
   logic            busy;
   logic            done;

`ifdef JESD204B_SYSREF_GEN_SKEW_EN
   logic [PH_W:0] skew_ext;
   assign skew_ext = {1'b0, i_skew};
   assign skew_in  = (skew_ext >= (PH_W+1)'(PERIOD))
                   ? PH_W'(skew_ext - (PH_W+1)'(PERIOD)) : i_skew;
`else
   assign skew_in = '0;
`endif

   // Launch one cycle early so the registered pulse is high at phase == skew.
   assign launch = (skew_q == '0) ? PH_W'(PERIOD - 1) : skew_q - PH_W'(1);

   jesd204b_sysref_phase_cnt #(
      .PERIOD (PERIOD),
      .PH_W   (PH_W)
   ) u_phase (
      .dclk   (dclk),
      .rst    (rst),
      .launch (launch),
      .phase  (phase),
      .hit    (hit)
   );

   assign cnt_inc = {1'b0, pulse_cnt} + 9'd1;

   always_comb begin
      last_pulse = 1'b1;
      case (mode_q)
         MODE_GAPPED: last_pulse = (cnt_inc >= {1'b0, target});
         MODE_CONT:   last_pulse = 1'b0;
         default:     last_pulse = 1'b1;
      endcase
      if (stop_pend || i_stop) last_pulse = 1'b1;
   end

   always_ff @(posedge dclk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_ONESHOT;
         target    <= 8'd1;
         pulse_cnt <= '0;
         wcnt      <= '0;
         skew_q    <= '0;
         stop_pend <= 1'b0;
         sysref    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  state     <= ST_ARMED;
                  busy      <= 1'b1;
                  mode_q    <= mode_e'(i_mode);
                  target    <= (i_pulse_count == 8'd0) ? 8'd1 : i_pulse_count;
                  pulse_cnt <= '0;
                  skew_q    <= skew_in;
                  stop_pend <= 1'b0;
               end
            end
            ST_ARMED, ST_GAP: begin
               if (i_stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (hit) begin
                  state  <= ST_PULSE;
                  sysref <= 1'b1;
                  wcnt   <= '0;
               end
            end
            ST_PULSE: begin
               if (wcnt == W_LAST) begin
                  sysref    <= 1'b0;
                  pulse_cnt <= cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
                  if (last_pulse) begin
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     stop_pend <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
               end else begin
                  wcnt <= wcnt + PH_W'(1);
                  if (i_stop) stop_pend <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_sysref    = sysref;
   assign o_busy      = busy;
   assign o_done      = done;
   assign o_pulse_cnt = pulse_cnt;
   assign o_phase     = phase;

endmodule
